// File: rtl/bus_params_pkg.sv
// Host-side TL-UL bus widths shared by the crossbar and its adapters.
package bus_params_pkg;
  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_AIW = 8;
endpackage

// File: rtl/tl_downsizer_pkg.sv
// Opcodes, FSM states and width helpers for the TL-UL data-width downsizer.
package tl_downsizer_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RESPOND
  } state_e;

  function automatic int ds_ratio(input int host_dw, input int dev_dw);
    return host_dw / dev_dw;
  endfunction

  function automatic int ds_idx_w(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

  function automatic logic op_supported(input logic [2:0] op);
    return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL) || (op == A_GET);
  endfunction

endpackage

// File: rtl/tl_downsizer_beat_sel.sv
// Active-beat selector: a Get touches every beat, a Put only beats with a nonzero mask slice.
module tl_downsizer_beat_sel #(
  parameter int RATIO = 4,
  parameter int IDXW  = 2,
  parameter int SLW   = 1
) (
  input  logic [RATIO*SLW-1:0] mask_i,
  input  logic                 is_get_i,
  input  logic [IDXW-1:0]      k_i,
  output logic [IDXW-1:0]      first_o,
  output logic [IDXW-1:0]      next_o,
  output logic                 last_o,
  output logic                 any_o
);

  logic [RATIO-1:0] act;

  always_comb begin
    act = '0;
    for (int i = 0; i < RATIO; i++) begin
      act[i] = is_get_i || (|mask_i[i*SLW +: SLW]);
    end
  end

  always_comb begin
    logic found_f;
    logic found_n;
    found_f = 1'b0;
    found_n = 1'b0;
    first_o = '0;
    next_o  = k_i;
    for (int i = 0; i < RATIO; i++) begin
      if (act[i] && !found_f) begin
        first_o = IDXW'(i);
        found_f = 1'b1;
      end
      if (act[i] && !found_n && (i > int'(k_i))) begin
        next_o  = IDXW'(i);
        found_n = 1'b1;
      end
    end
    last_o = !found_n;
    any_o  = |act;
  end

endmodule

// File: rtl/tl_bus_downsizer.sv
// TL-UL downsizer: splits one wide host request into narrow device beats and merges the replies.
// Optional build macro TL_DOWNSIZER_ERR_ABORT_EN: the first device error ends the transaction early.
//
// state       | meaning
// ST_IDLE     | ready for a host request
// ST_ISSUE    | presenting device beat k
// ST_WAIT_RSP | waiting for the device response to beat k
// ST_RESPOND  | presenting the merged host response
module tl_bus_downsizer
  import tl_downsizer_pkg::*;
#(
  parameter int AW      = bus_params_pkg::BUS_AW,
  parameter int HOST_DW = bus_params_pkg::BUS_DW,
  parameter int DEV_DW  = 8,
  parameter int SRCW    = bus_params_pkg::BUS_AIW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  h_a_valid_i,
  output logic                  h_a_ready_o,
  input  logic [2:0]            h_a_opcode_i,
  input  logic [AW-1:0]         h_a_address_i,
  input  logic [SRCW-1:0]       h_a_source_i,
  input  logic [HOST_DW-1:0]    h_a_data_i,
  input  logic [HOST_DW/8-1:0]  h_a_mask_i,
  output logic                  h_d_valid_o,
  input  logic                  h_d_ready_i,
  output logic [2:0]            h_d_opcode_o,
  output logic [SRCW-1:0]       h_d_source_o,
  output logic [HOST_DW-1:0]    h_d_data_o,
  output logic                  h_d_error_o,
  output logic                  d_a_valid_o,
  input  logic                  d_a_ready_i,
  output logic [2:0]            d_a_opcode_o,
  output logic [AW-1:0]         d_a_address_o,
  output logic [DEV_DW-1:0]     d_a_data_o,
  output logic [DEV_DW/8-1:0]   d_a_mask_o,
  input  logic                  d_d_valid_i,
  output logic                  d_d_ready_o,
  input  logic [DEV_DW-1:0]     d_d_data_i,
  input  logic                  d_d_error_i
);

  localparam int RATIO = ds_ratio(HOST_DW, DEV_DW);
  localparam int IDXW  = ds_idx_w(RATIO);
  localparam int MW    = HOST_DW / 8;
  localparam int SLW   = DEV_DW / 8;
  localparam int HBW   = $clog2(MW);
  localparam int SLB   = $clog2(SLW);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [SRCW-1:0]     src_q, src_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [HOST_DW-1:0]  wdata_q, wdata_d;
  logic [MW-1:0]       mask_q, mask_d;
  logic [IDXW-1:0]     k_q, k_d;
  logic [HOST_DW-1:0]  rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [MW-1:0]       sel_mask;
  logic                sel_get;
  logic [IDXW-1:0]     sel_first, sel_next;
  logic                sel_last, sel_any;
  logic [SLW-1:0]      slice_mask;
  logic                unused_addr;

  assign unused_addr = ^h_a_address_i[HBW-1:0];

  // In IDLE the selector looks at the incoming request so the first beat is known at accept.
  assign sel_mask = (state_q == ST_IDLE) ? h_a_mask_i : mask_q;
  assign sel_get  = (state_q == ST_IDLE) ? (h_a_opcode_i == A_GET) : (op_q == A_GET);

  tl_downsizer_beat_sel #(
    .RATIO (RATIO),
    .IDXW  (IDXW),
    .SLW   (SLW)
  ) u_beat_sel (
    .mask_i   (sel_mask),
    .is_get_i (sel_get),
    .k_i      (k_q),
    .first_o  (sel_first),
    .next_o   (sel_next),
    .last_o   (sel_last),
    .any_o    (sel_any)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    k_d     = k_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (h_a_valid_i) begin
          op_d    = h_a_opcode_i;
          src_d   = h_a_source_i;
          wdata_d = h_a_data_i;
          mask_d  = h_a_mask_i;
          addr_d  = {h_a_address_i[AW-1:HBW], {HBW{1'b0}}};
          rdata_d = '0;
          err_d   = 1'b0;
          if (!op_supported(h_a_opcode_i)) begin
            err_d   = 1'b1;
            state_d = ST_RESPOND;
          end else if (!sel_any) begin
            state_d = ST_RESPOND;
          end else begin
            k_d     = sel_first;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (d_a_ready_i) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (d_d_valid_i) begin
          if (op_q == A_GET) rdata_d[k_q*DEV_DW +: DEV_DW] = d_d_data_i;
          err_d = err_q | d_d_error_i;
          if (sel_last) begin
            state_d = ST_RESPOND;
          end else begin
            k_d     = sel_next;
            state_d = ST_ISSUE;
          end
`ifdef TL_DOWNSIZER_ERR_ABORT_EN
          if (d_d_error_i) state_d = ST_RESPOND;
`endif
        end
      end
      ST_RESPOND: begin
        if (h_d_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      k_q     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      k_q     <= k_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign slice_mask = mask_q[k_q*SLW +: SLW];

  // A Put beat whose lane is only partly enabled must not claim to be a full write.
  always_comb begin
    d_a_opcode_o = op_q;
    if ((op_q != A_GET) && (slice_mask != {SLW{1'b1}})) d_a_opcode_o = A_PUT_PARTIAL;
  end

  assign h_a_ready_o   = (state_q == ST_IDLE);
  assign d_a_valid_o   = (state_q == ST_ISSUE);
  assign d_a_address_o = addr_q + (AW'(k_q) << SLB);
  assign d_a_data_o    = wdata_q[k_q*DEV_DW +: DEV_DW];
  assign d_a_mask_o    = slice_mask;
  assign d_d_ready_o   = (state_q == ST_WAIT_RSP);
  assign h_d_valid_o   = (state_q == ST_RESPOND);
  assign h_d_opcode_o  = (op_q == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
  assign h_d_source_o  = src_q;
  assign h_d_data_o    = rdata_q;
  assign h_d_error_o   = err_q;

endmodule

// File: tb/tb_tl_bus_downsizer.sv
// Scoreboard bench for tl_bus_downsizer with HOST_DW=32, DEV_DW=8.
module tb_tl_bus_downsizer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        h_a_valid_i = 1'b0;
  logic        h_a_ready_o;
  logic [2:0]  h_a_opcode_i = '0;
  logic [31:0] h_a_address_i = '0;
  logic [7:0]  h_a_source_i = '0;
  logic [31:0] h_a_data_i = '0;
  logic [3:0]  h_a_mask_i = '0;
  logic        h_d_valid_o;
  logic        h_d_ready_i = 1'b0;
  logic [2:0]  h_d_opcode_o;
  logic [7:0]  h_d_source_o;
  logic [31:0] h_d_data_o;
  logic        h_d_error_o;
  logic        d_a_valid_o;
  logic        d_a_ready_i = 1'b0;
  logic [2:0]  d_a_opcode_o;
  logic [31:0] d_a_address_o;
  logic [7:0]  d_a_data_o;
  logic [0:0]  d_a_mask_o;
  logic        d_d_valid_i = 1'b0;
  logic        d_d_ready_o;
  logic [7:0]  d_d_data_i = '0;
  logic        d_d_error_i = 1'b0;

  always #5 clk_i = ~clk_i;

  tl_bus_downsizer #(
    .AW(32), .HOST_DW(32), .DEV_DW(8), .SRCW(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .h_a_valid_i(h_a_valid_i), .h_a_ready_o(h_a_ready_o), .h_a_opcode_i(h_a_opcode_i),
    .h_a_address_i(h_a_address_i), .h_a_source_i(h_a_source_i), .h_a_data_i(h_a_data_i),
    .h_a_mask_i(h_a_mask_i),
    .h_d_valid_o(h_d_valid_o), .h_d_ready_i(h_d_ready_i), .h_d_opcode_o(h_d_opcode_o),
    .h_d_source_o(h_d_source_o), .h_d_data_o(h_d_data_o), .h_d_error_o(h_d_error_o),
    .d_a_valid_o(d_a_valid_o), .d_a_ready_i(d_a_ready_i), .d_a_opcode_o(d_a_opcode_o),
    .d_a_address_o(d_a_address_o), .d_a_data_o(d_a_data_o), .d_a_mask_o(d_a_mask_o),
    .d_d_valid_i(d_d_valid_i), .d_d_ready_o(d_d_ready_o), .d_d_data_i(d_d_data_i),
    .d_d_error_i(d_d_error_i)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
    logic [0:0]  mask;
    logic [2:0]  op;
  } beat_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  beat_t       exp_beats[$];
  rsp_t        exp_rsp[$];
  logic [7:0]  dev_mem [4];
  int          err_lane = 9;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_h_data;
  logic        last_h_err;

  // Reference model: expected device beats and merged host response for one request.
  task automatic expect_txn(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src,
                            input logic [31:0] data, input logic [3:0] mask);
    beat_t b;
    rsp_t  r;
    bit    stop = 0;
    logic [31:0] base = {addr[31:2], 2'b00};
    r.op   = (op == 3'd4) ? 3'd1 : 3'd0;
    r.src  = src;
    r.data = '0;
    r.err  = 1'b0;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) begin
      r.err = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (((op == 3'd4) || mask[i]) && !stop) begin
          b.addr = base + 32'(i);
          b.data = data[i*8 +: 8];
          b.mask = mask[i];
          b.op   = (op == 3'd4) ? 3'd4 : (mask[i] ? op : 3'd1);
          exp_beats.push_back(b);
          if (op == 3'd4) r.data[i*8 +: 8] = dev_mem[i];
          if (i == err_lane) begin
            r.err = 1'b1;
`ifdef TL_DOWNSIZER_ERR_ABORT_EN
            stop = 1;
`endif
          end
        end
      end
    end
    exp_rsp.push_back(r);
  endtask

  // Called at a negedge with the DUT in IDLE; the request is taken at the next posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src,
                       input logic [31:0] data, input logic [3:0] mask);
    expect_txn(op, addr, src, data, mask);
    checks++;
    if (h_a_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL h_a_ready_idle got=%b want=1", h_a_ready_o);
    end
    h_a_valid_i   = 1'b1;
    h_a_opcode_i  = op;
    h_a_address_i = addr;
    h_a_source_i  = src;
    h_a_data_i    = data;
    h_a_mask_i    = mask;
  endtask

  // Acts as device and host response sink until the host response handshake completes.
  task automatic run_txn(input int da_stall, input int hd_stall, input bit chk_lat);
    int    cyc = 0;
    bit    done = 0;
    bit    first_rsp = 1;
    int    sa = da_stall;
    int    sh = hd_stall;
    int    n_exp = exp_beats.size();
    logic [31:0] last_addr = '0;
    beat_t eb;
    rsp_t  er;
    while (!done && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
      h_a_valid_i = 1'b0;
      d_a_ready_i = 1'b0;
      d_d_valid_i = 1'b0;
      h_d_ready_i = 1'b0;
      if (d_a_valid_o) begin
        checks++;
        if (exp_beats.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected got addr=%h data=%h want no beat", d_a_address_o, d_a_data_o);
          d_a_ready_i = 1'b1;
          last_addr   = d_a_address_o;
        end else begin
          eb = exp_beats[0];
          if ({d_a_address_o, d_a_data_o, d_a_mask_o, d_a_opcode_o} !== eb) begin
            errors++;
            $display("FAIL beat got addr=%h data=%h mask=%b op=%0d want addr=%h data=%h mask=%b op=%0d",
                     d_a_address_o, d_a_data_o, d_a_mask_o, d_a_opcode_o, eb.addr, eb.data, eb.mask, eb.op);
          end
          if (sa > 0) sa--;
          else begin
            void'(exp_beats.pop_front());
            d_a_ready_i = 1'b1;
            last_addr   = d_a_address_o;
            sa          = da_stall;
          end
        end
      end
      if (d_d_ready_o) begin
        d_d_valid_i = 1'b1;
        d_d_data_i  = dev_mem[last_addr[1:0]];
        d_d_error_i = (int'(last_addr[1:0]) == err_lane);
      end
      if (h_d_valid_o) begin
        if (chk_lat && first_rsp) begin
          checks++;
          if (cyc != 2*n_exp + 1) begin
            errors++;
            $display("FAIL latency got=%0d want=%0d", cyc, 2*n_exp + 1);
          end
        end
        first_rsp = 0;
        checks++;
        if (exp_rsp.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got data=%h", h_d_data_o);
          h_d_ready_i = 1'b1;
          done = 1;
        end else begin
          er = exp_rsp[0];
          if ({h_d_opcode_o, h_d_source_o, h_d_data_o, h_d_error_o} !== er) begin
            errors++;
            $display("FAIL rsp got op=%0d src=%h data=%h err=%b want op=%0d src=%h data=%h err=%b",
                     h_d_opcode_o, h_d_source_o, h_d_data_o, h_d_error_o, er.op, er.src, er.data, er.err);
          end
          last_h_data = h_d_data_o;
          last_h_err  = h_d_error_o;
          if (sh > 0) sh--;
          else begin
            void'(exp_rsp.pop_front());
            h_d_ready_i = 1'b1;
            done = 1;
          end
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout got cycles=%0d want response", cyc);
    end
    checks++;
    if (exp_beats.size() != 0) begin
      errors++;
      $display("FAIL beats_missing got remaining=%0d want 0", exp_beats.size());
    end
    @(negedge clk_i);
    h_d_ready_i = 1'b0;
    d_a_ready_i = 1'b0;
    d_d_valid_i = 1'b0;
    d_d_error_i = 1'b0;
    exp_beats.delete();
    exp_rsp.delete();
  endtask

  task automatic set_mem(input logic [31:0] v, input int el);
    for (int i = 0; i < 4; i++) dev_mem[i] = v[i*8 +: 8];
    err_lane = el;
  endtask

  task automatic test_reset();
    checks++;
    if ({h_a_ready_o, d_a_valid_o, d_d_ready_o, h_d_valid_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_handshake got=%b want=1000", {h_a_ready_o, d_a_valid_o, d_d_ready_o, h_d_valid_o});
    end
    checks++;
    if ({h_d_data_o, h_d_error_o, d_a_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got data=%h err=%b beat=%h want 0", h_d_data_o, h_d_error_o, d_a_data_o);
    end
  endtask

  task automatic test_get();
    set_mem(32'h44332211, 9);
    issue(3'd4, 32'h100, 8'h5A, 32'h0, 4'hF);
    run_txn(0, 0, 1);
    checks++;
    if (last_h_data !== 32'h44332211) begin
      errors++;
      $display("FAIL get_data got=%h want=44332211", last_h_data);
    end
  endtask

  task automatic test_put_full();
    issue(3'd0, 32'h200, 8'h11, 32'hAABBCCDD, 4'hF);
    run_txn(0, 0, 1);
  endtask

  task automatic test_put_partial();
    issue(3'd1, 32'h107, 8'h22, 32'h12345678, 4'b0100);
    run_txn(0, 0, 1);
  endtask

  task automatic test_no_beat();
    issue(3'd0, 32'h300, 8'h33, 32'hFFFFFFFF, 4'h0);
    run_txn(0, 0, 1);
    issue(3'd3, 32'h300, 8'h44, 32'hFFFFFFFF, 4'hF);
    run_txn(0, 0, 1);
    checks++;
    if (last_h_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_opcode_err got=%b want=1", last_h_err);
    end
  endtask

  task automatic test_err();
    set_mem(32'h44332211, 1);
    issue(3'd4, 32'h100, 8'h66, 32'h0, 4'hF);
    run_txn(0, 0, 1);
    checks++;
`ifdef TL_DOWNSIZER_ERR_ABORT_EN
    if ({last_h_data, last_h_err} !== {32'h00002211, 1'b1}) begin
      errors++;
      $display("FAIL err_abort got data=%h err=%b want data=00002211 err=1", last_h_data, last_h_err);
    end
`else
    if ({last_h_data, last_h_err} !== {32'h44332211, 1'b1}) begin
      errors++;
      $display("FAIL err_accum got data=%h err=%b want data=44332211 err=1", last_h_data, last_h_err);
    end
`endif
  endtask

  task automatic test_backpressure();
    set_mem(32'hDEADBEEF, 9);
    issue(3'd4, 32'h400, 8'h77, 32'h0, 4'hF);
    run_txn(5, 3, 0);
    issue(3'd0, 32'h404, 8'h78, 32'h01020304, 4'b1010);
    run_txn(5, 3, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 5))
        0: op = 3'd0;
        1: op = 3'd1;
        2, 3: op = 3'd4;
        4: op = 3'd3;
        default: op = 3'd7;
      endcase
      set_mem($urandom, int'($urandom_range(0, 6)));
      issue(op, $urandom, 8'($urandom), $urandom, 4'($urandom));
      run_txn(0, 0, 1);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    set_mem(32'h55667788, 9);
    issue(3'd4, 32'h500, 8'h99, 32'h0, 4'hF);
    exp_beats.delete();
    exp_rsp.delete();
    do begin
      @(negedge clk_i);
      cyc++;
      h_a_valid_i = 1'b0;
      d_a_ready_i = d_a_valid_o;
    end while (!d_d_ready_o && cyc < 20);
    checks++;
    if (d_d_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reach_wait_rsp got=%b want=1", d_d_ready_o);
    end
    d_a_ready_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({h_a_ready_o, d_a_valid_o, d_d_ready_o, h_d_valid_o, h_d_error_o} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_mid got=%b want=10000",
               {h_a_ready_o, d_a_valid_o, d_d_ready_o, h_d_valid_o, h_d_error_o});
    end
    rst_ni = 1'b1;
    set_mem(32'hCAFEF00D, 9);
    issue(3'd4, 32'h600, 8'hAB, 32'h0, 4'hF);
    run_txn(0, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_get();
    test_put_full();
    test_put_partial();
    test_no_beat();
    test_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
